// File: rtl/jk_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : jk_bcd_counter
// Brief    : Up/down modulo-N counter built from master-slave JK cells, with
//            parallel load, load clamping and terminal-count ripple output.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bcd_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] qm,
    output logic [WIDTH-1:0] qs,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   c_MOD  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_qm;
    logic [WIDTH-1:0] r_qs;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_qm_next;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_dn_target;
    logic [WIDTH-1:0] w_up_diff;
    logic [WIDTH-1:0] w_dn_diff;
    logic             w_at_last;
    logic             w_at_zero;
    logic             w_out_of_range;

    assign w_at_last      = (r_qs == c_LAST);
    assign w_at_zero      = (r_qs == '0);
    assign w_out_of_range = (r_qs > c_LAST);

    // Out-of-range load values saturate at the top of the count range.
    assign w_load_val  = ({1'b0, din} >= c_MOD) ? c_LAST : din;
    assign w_inc       = r_qs + WIDTH'(1);
    assign w_dec       = r_qs - WIDTH'(1);
    assign w_dn_target = (w_at_zero || w_out_of_range) ? c_LAST : w_dec;
    assign w_up_diff   = r_qs ^ w_inc;
    assign w_dn_diff   = r_qs ^ w_dn_target;

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (load) begin
            w_j = w_load_val;
            w_k = ~w_load_val;
        end else if (en) begin
            if (up) begin
                if (w_at_last || w_out_of_range) begin
                    // Wrap (or recovery) to zero: clear every bit that is set.
                    w_j = '0;
                    w_k = r_qs;
                end else begin
                    w_j = w_up_diff;
                    w_k = w_up_diff;
                end
            end else begin
                w_j = w_dn_diff;
                w_k = w_dn_diff;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_cell
            assign w_qm_next[gi] = (w_j[gi] & ~r_qs[gi]) | (~w_k[gi] & r_qs[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qm <= '0;
        end else begin
            r_qm <= w_qm_next;
        end
    end

    // Slave stage transfers on the falling edge; reset clears both stages.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_qs <= '0;
        end else begin
            r_qs <= r_qm;
        end
    end

    assign qm = r_qm;
    assign qs = r_qs;
    assign tc = en & ~load & ((up & w_at_last) | (~up & w_at_zero));

endmodule
`default_nettype wire

// File: tb/tb_jk_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bcd_counter
// Brief    : Scoreboard bench for jk_bcd_counter (WIDTH=4, MODULUS=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bcd_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] qm;
    logic [3:0] qs;
    logic       tc;

    typedef struct {
        logic [3:0] qs_pos;
        logic [3:0] qs_neg;
        logic       tc_neg;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] prev_qs;
    int         n_checks;
    int         n_fail;

    jk_bcd_counter #(
        .WIDTH  (4),
        .MODULUS(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .up  (up),
        .load(load),
        .din (din),
        .qm  (qm),
        .qs  (qs),
        .tc  (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs in the low phase and queue the expected result.
    task automatic step(input logic l, input logic [3:0] d, input logic e, input logic u,
                        input logic [3:0] exp_qs, input logic exp_tc);
        load = l;
        din  = d;
        en   = e;
        up   = u;
        sb_q.push_back('{prev_qs, exp_qs, exp_tc});
        prev_qs = exp_qs;
        @(negedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        logic have;
        forever begin
            @(posedge clk);
            #1;
            have = (sb_q.size() > 0);
            if (have) begin
                e = sb_q[0];
                chk("qm_lead", 32'(qm), 32'(e.qs_neg));
                chk("qs_lag", 32'(qs), 32'(e.qs_pos));
            end
            @(negedge clk);
            #1;
            if (have) begin
                e = sb_q.pop_front();
                chk("qs", 32'(qs), 32'(e.qs_neg));
                chk("tc", 32'(tc), 32'(e.tc_neg));
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        prev_qs  = 4'd0;
        clk  = 1'b0;
        rst  = 1'b1;
        en   = 1'b1;
        up   = 1'b0;
        load = 1'b0;
        din  = 4'd0;

        // Reset state, with tc reflecting qs=0 while counting down.
        #7;
        chk("rst_qm", 32'(qm), 32'd0);
        chk("rst_qs", 32'(qs), 32'd0);
        chk("rst_tc", 32'(tc), 32'd1);
        #3;
        rst = 1'b0;
        up  = 1'b1;
        #2;

        // Count up through the wrap.
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 4'd0, 1'b1, 1'b1, 4'(i), (i == 9));
        end
        step(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0);

        // Load 2 and count down through the wrap.
        step(1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0);

        // Load priority over enable, clamp, then hold.
        step(1'b1, 4'd13, 1'b1, 1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        end

        // Mid-operation reset during the high phase.
        step(1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b0);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_qm", 32'(qm), 32'd0);
        chk("mid_rst_qs", 32'(qs), 32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_qs_fall", 32'(qs), 32'd0);
        #1;
        prev_qs = 4'd0;
        step(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0);

        // Self-recovery from an illegal state, counting up then down.
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        force dut.r_qs = 4'd12;
        sb_q.push_back('{4'd12, 4'd0, 1'b0});
        @(posedge clk);
        #3;
        release dut.r_qs;
        @(negedge clk);
        #2;
        up = 1'b0;
        force dut.r_qs = 4'd12;
        sb_q.push_back('{4'd12, 4'd9, 1'b0});
        @(posedge clk);
        #3;
        release dut.r_qs;
        @(negedge clk);
        #2;
        prev_qs = 4'd9;
        step(1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
